freq_meter: RTL

Measures the frequency of an asynchronous external signal by counting its rising edges over a fixed gate window. The window is derived from the system clock: DIV = CLK_HZ / GATE_HZ cycles. At the end of each window the block publishes the edge count with a one-cycle valid strobe. It consumes a periodic signal where the divider produces one, e.g. for checking PLL outputs, sensor pulse trains and loopback of divided clocks on the ice40 sandbox boards.

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/edge_sync.sv | 35 +++
 rtl/freq_meter.sv | 110 +++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared constants and helpers for the frequency meter.
//   calc_div   - gate window length in system clock cycles
//   gcnt_width - width of the gate counter for a given window length
//   sat_max    - saturation value of a CNT_W-bit edge count
package freq_meter_pkg;

    // Gate window length in clk cycles.
    function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned gate_hz);
        return clk_hz / gate_hz;
    endfunction

    // Gate counter width; never narrower than one bit.
    function automatic int unsigned gcnt_width(int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Largest value a cnt_w-bit count can hold (2^cnt_w - 1).
    function automatic longint unsigned sat_max(int unsigned cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer followed by a rising-edge detector.
// Reusable for any asynchronous single-bit input (pulse trains, buttons).
//   clk    - system clock
//   rst    - synchronous active-high reset, clears all flops
//   d      - asynchronous input
//   q_sync - synchronized level of d
//   rise   - one-cycle pulse on a synchronized 0->1 transition
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q_sync = s2_q;
    assign rise   = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous signal over fixed gate
// windows of DIV = CLK_HZ / GATE_HZ clk cycles and publishes each result.
//   clk      - system clock, the only clock domain
//   rst      - synchronous active-high reset
//   en       - measurement enable; low clears the window in progress
//   sig_in   - measured signal, asynchronous to clk
//   count    - saturating edge count of the last completed window
//   valid    - one-cycle strobe when count/overflow update
//   overflow - the last completed window saturated
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter int unsigned GATE_HZ = 1,
    parameter int unsigned CNT_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow
);

    localparam int unsigned      Div      = calc_div(CLK_HZ, GATE_HZ);
    localparam int unsigned      GcntW    = gcnt_width(Div);
    localparam logic [GcntW-1:0] GateLast = GcntW'(Div - 1);
    localparam logic [CNT_W-1:0] SatMax   = CNT_W'(sat_max(CNT_W));

    logic             rise;
    logic             unused_sig_sync;

    logic [GcntW-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;

    logic             gate_end;
    logic [CNT_W:0]   sum;
    logic             sum_sat;
    logic [CNT_W-1:0] acc_sat;

    edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .q_sync (unused_sig_sync),
        .rise   (rise)
    );

    assign gate_end = en & (gcnt_q == GateLast);

    // Carry out of the widened add means acc was already at SatMax.
    assign sum     = {1'b0, acc_q} + (CNT_W + 1)'(rise);
    assign sum_sat = sum[CNT_W];
    assign acc_sat = sum_sat ? SatMax : sum[CNT_W-1:0];

    always_comb begin
        gcnt_d     = gcnt_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        if (!en) begin
            gcnt_d    = '0;
            acc_d     = '0;
            ovf_acc_d = 1'b0;
        end else if (gate_end) begin
            // The rise of the final cycle still belongs to the ending window.
            gcnt_d     = '0;
            acc_d      = '0;
            ovf_acc_d  = 1'b0;
            count_d    = acc_sat;
            overflow_d = ovf_acc_q | sum_sat;
            valid_d    = 1'b1;
        end else begin
            gcnt_d    = gcnt_q + GcntW'(1);
            acc_d     = acc_sat;
            ovf_acc_d = ovf_acc_q | sum_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q     <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            gcnt_q     <= gcnt_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule
